// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes ps2_clk/ps2_dat, deserializes 11-bit frames and buffers good bytes in a FWFT FIFO.
// Optional frame timeout is enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ps2_clk,
  input  logic          ps2_dat,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW:0]   count,
  output logic          frame_err,
  output logic          overflow,
  input  logic          clr_err,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  state_t      state, state_n;
  logic [2:0]  clk_sync;
  logic [1:0]  dat_sync;
  logic        fall;
  logic        dat;
  logic [2:0]  bitcnt, bitcnt_n;
  logic [7:0]  shreg, shreg_n;
  logic        par, par_n;
  logic        good, bad;
  logic        timeout_hit;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        full, push, pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  assign fall = clk_sync[2] & ~clk_sync[1];
  assign dat  = dat_sync[1];

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Counter only runs mid-frame; every falling edge restarts the window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || fall) begin
      tmo_cnt <= '0;
    end else if (!timeout_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      bitcnt <= '0;
      shreg  <= '0;
      par    <= 1'b0;
    end else begin
      state  <= state_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
      par    <= par_n;
    end
  end

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    par_n    = par;
    good     = 1'b0;
    bad      = 1'b0;
    if (fall) begin
      case (state)
        IDLE: begin
          if (!dat) begin
            state_n  = DATA;
            bitcnt_n = 3'd0;
          end
        end
        DATA: begin
          shreg_n  = {dat, shreg[7:1]};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = dat;
          state_n = STOP;
        end
        STOP: begin
          // Odd parity: data bits plus parity bit must contain an odd number of ones.
          if (dat && ((^shreg) ^ par)) good = 1'b1;
          else                         bad  = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_n = IDLE;
      shreg_n = '0;
      bad     = 1'b1;
    end
  end

  assign fsm_state = state;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_valid = (wptr != rptr);
  assign count    = wptr - rptr;
  assign push     = good & ~full;
  assign pop      = rd_valid & rd_ready;
  assign rd_data  = rd_valid ? mem[rptr[AW-1:0]] : 8'h00;

  always_ff @(posedge clock) begin
    if (push) mem[wptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (bad)          frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (good && full) overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
    end
  end

endmodule
